// File: rtl/trig_pkg.sv
// Shared constants and helpers for the multi-channel trigger counter bank.
package trig_pkg;

  localparam int CNT_W_DEF = 16;

  localparam bit EDGE  = 1'b1;
  localparam bit LEVEL = 1'b0;

  // All-ones value of a counter of the given width (width 1..32).
  function automatic logic [31:0] cnt_max(input int width);
    logic [63:0] full;
    full = (64'd1 << width) - 64'd1;
    return full[31:0];
  endfunction

endpackage

// File: rtl/trig_counter_ch.sv
// One trigger channel: event detect, saturating counter, saturation flag and
// shadow snapshot register.
import trig_pkg::*;

module trig_counter_ch #(
  parameter int CNT_W     = CNT_W_DEF,
  parameter bit EDGE_MODE = EDGE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             enable,
  input  logic             clear,
  input  logic             latch,
  output logic             sat,
  output logic [CNT_W-1:0] shadow
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             hist;
  logic             hit;

  assign hit      = (EDGE_MODE == EDGE) ? (in & ~hist) : in;
  assign cnt_next = cnt + ONE;

  // The snapshot takes the pre-update count, so it is independent of clear and
  // increment; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      sat    <= 1'b0;
      hist   <= 1'b0;
      shadow <= '0;
    end else begin
      hist <= in;
      if (latch)
        shadow <= cnt;
      if (clear) begin
        cnt <= '0;
        sat <= 1'b0;
      end else if (hit && enable && (cnt != MAX)) begin
        cnt <= cnt_next;
        sat <= (cnt_next == MAX);
      end
    end
  end

endmodule

// File: rtl/trig_counter_bank.sv
// N_CH-channel trigger counter bank with snapshot shadow registers and a
// registered readout mux.
import trig_pkg::*;

module trig_counter_bank #(
  parameter  int N_CH      = 8,
  parameter  int CNT_W     = CNT_W_DEF,
  parameter  bit EDGE_MODE = EDGE,
  localparam int SEL_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  in,
  input  logic             enable,
  input  logic             clear,
  input  logic             latch,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic [N_CH-1:0]  sat,
  output logic             latched_valid
);

  logic [CNT_W-1:0] shadow [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    trig_counter_ch #(
      .CNT_W     (CNT_W),
      .EDGE_MODE (EDGE_MODE)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .in     (in[i]),
      .enable (enable),
      .clear  (clear),
      .latch  (latch),
      .sat    (sat[i]),
      .shadow (shadow[i])
    );
  end

  // Selects beyond the last channel read as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data       <= '0;
      latched_valid <= 1'b0;
    end else begin
      latched_valid <= latch;
      if (int'(rd_sel) < N_CH)
        rd_data <= shadow[rd_sel];
      else
        rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_trig_counter_bank.sv
// Directed bench: an edge-mode 6-channel 16-bit bank and a level-mode
// 8-channel 8-bit bank driven side by side.
module tb_trig_counter_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic [5:0]  e_in = '0;
  logic        e_enable = 1'b0, e_clear = 1'b0, e_latch = 1'b0;
  logic [2:0]  e_rd_sel = '0;
  logic [15:0] e_rd_data;
  logic [5:0]  e_sat;
  logic        e_lv;

  logic [7:0]  l_in = '0;
  logic        l_enable = 1'b0, l_clear = 1'b0, l_latch = 1'b0;
  logic [2:0]  l_rd_sel = '0;
  logic [7:0]  l_rd_data;
  logic [7:0]  l_sat;
  logic        l_lv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trig_counter_bank #(.N_CH(6), .CNT_W(16), .EDGE_MODE(1'b1)) dut_e (
    .clk(clk), .reset(reset), .in(e_in), .enable(e_enable), .clear(e_clear),
    .latch(e_latch), .rd_sel(e_rd_sel), .rd_data(e_rd_data), .sat(e_sat),
    .latched_valid(e_lv)
  );

  trig_counter_bank #(.N_CH(8), .CNT_W(8), .EDGE_MODE(1'b0)) dut_l (
    .clk(clk), .reset(reset), .in(l_in), .enable(l_enable), .clear(l_clear),
    .latch(l_latch), .rd_sel(l_rd_sel), .rd_data(l_rd_data), .sat(l_sat),
    .latched_valid(l_lv)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] sweep_exp [8];
    sweep_exp = '{16'd3, 16'd2, 16'd2, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0};

    #2 reset = 1'b1;
    #1;
    checkOutput("reset_e_rd_data", 32'(e_rd_data), 32'd0);
    checkOutput("reset_e_sat", 32'(e_sat), 32'd0);
    checkOutput("reset_e_lv", 32'(e_lv), 32'd0);
    checkOutput("reset_l_rd_data", 32'(l_rd_data), 32'd0);
    checkOutput("reset_l_sat", 32'(l_sat), 32'd0);
    checkOutput("reset_l_lv", 32'(l_lv), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    e_enable = 1'b1;
    l_enable = 1'b1;

    // Edge mode: a long high pulse counts once.
    e_in[0] = 1'b1;
    repeat (10) tick();
    e_in[0] = 1'b0;
    tick();
    e_latch = 1'b1;
    tick();
    e_latch = 1'b0;
    checkOutput("edge_lv_pulse", 32'(e_lv), 32'd1);
    checkOutput("edge_rd_latency", 32'(e_rd_data), 32'd0);
    tick();
    checkOutput("edge_rd_data", 32'(e_rd_data), 32'd1);
    checkOutput("edge_lv_end", 32'(e_lv), 32'd0);

    // Level mode: five high cycles give five counts.
    l_rd_sel = 3'd3;
    l_in[3] = 1'b1;
    repeat (5) tick();
    l_in[3] = 1'b0;
    l_latch = 1'b1;
    tick();
    l_latch = 1'b0;
    checkOutput("level_lv_pulse", 32'(l_lv), 32'd1);
    tick();
    checkOutput("level_rd_ch3", 32'(l_rd_data), 32'd5);
    checkOutput("level_lv_end", 32'(l_lv), 32'd0);
    l_rd_sel = 3'd0;
    tick();
    checkOutput("level_rd_ch0", 32'(l_rd_data), 32'd0);

    // Saturation at 255 without wrap, then clear.
    l_rd_sel = 3'd1;
    l_in[1] = 1'b1;
    repeat (254) tick();
    checkOutput("sat_before", 32'(l_sat), 32'h00);
    tick();
    checkOutput("sat_reached", 32'(l_sat), 32'h02);
    repeat (45) tick();
    l_latch = 1'b1;
    tick();
    l_latch = 1'b0;
    tick();
    checkOutput("sat_no_wrap", 32'(l_rd_data), 32'd255);
    checkOutput("sat_held", 32'(l_sat), 32'h02);
    l_clear = 1'b1;
    tick();
    l_clear = 1'b0;
    l_in[1] = 1'b0;
    checkOutput("sat_cleared", 32'(l_sat), 32'h00);
    l_latch = 1'b1;
    tick();
    l_latch = 1'b0;
    tick();
    checkOutput("clear_count", 32'(l_rd_data), 32'd0);

    // Latch, clear and a count event in the same cycle.
    l_rd_sel = 3'd2;
    l_in[2] = 1'b1;
    repeat (7) tick();
    l_latch = 1'b1;
    l_clear = 1'b1;
    tick();
    l_latch = 1'b0;
    l_clear = 1'b0;
    l_in[2] = 1'b0;
    checkOutput("simul_lv", 32'(l_lv), 32'd1);
    tick();
    checkOutput("simul_shadow", 32'(l_rd_data), 32'd7);
    checkOutput("simul_lv_end", 32'(l_lv), 32'd0);
    l_latch = 1'b1;
    tick();
    l_latch = 1'b0;
    tick();
    checkOutput("simul_cleared", 32'(l_rd_data), 32'd0);

    // Build distinct counts, then edges with enable low must not count.
    e_in = 6'h3F;
    tick();
    e_in = 6'h00;
    tick();
    e_in = 6'h07;
    tick();
    e_in = 6'h00;
    tick();
    e_enable = 1'b0;
    repeat (3) begin
      e_in = 6'h3F;
      tick();
      e_in = 6'h00;
      tick();
    end
    e_latch = 1'b1;
    tick();
    e_latch = 1'b0;
    checkOutput("disabled_lv", 32'(e_lv), 32'd1);
    for (int j = 0; j < 8; j++) begin
      e_rd_sel = 3'(j);
      tick();
      checkOutput($sformatf("sweep_sel%0d", j), 32'(e_rd_data), 32'(sweep_exp[j]));
    end
    checkOutput("disabled_sat", 32'(e_sat), 32'd0);
    e_enable = 1'b1;

    // Asynchronous reset between clock edges, then first count after release.
    l_rd_sel = 3'd4;
    l_in[4] = 1'b1;
    repeat (4) tick();
    l_latch = 1'b1;
    tick();
    l_latch = 1'b0;
    tick();
    checkOutput("pre_reset_rd", 32'(l_rd_data), 32'd4);
    e_in[0] = 1'b1;
    e_rd_sel = 3'd0;
    e_latch = 1'b1;
    tick();
    e_latch = 1'b0;
    #3 reset = 1'b1;
    #1;
    checkOutput("async_e_rd_data", 32'(e_rd_data), 32'd0);
    checkOutput("async_e_lv", 32'(e_lv), 32'd0);
    checkOutput("async_l_rd_data", 32'(l_rd_data), 32'd0);
    checkOutput("async_l_sat", 32'(l_sat), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    e_in[0] = 1'b0;
    l_in[4] = 1'b0;
    e_latch = 1'b1;
    l_latch = 1'b1;
    tick();
    e_latch = 1'b0;
    l_latch = 1'b0;
    tick();
    checkOutput("post_reset_edge", 32'(e_rd_data), 32'd1);
    checkOutput("post_reset_level", 32'(l_rd_data), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trig_counter_bank.md
Name: trig_counter_bank

Overview:
Multi-channel, parametrised successor of the single-channel trigger counter. It counts trigger activity on N_CH independent inputs, in either level mode or rising-edge mode. Counters are CNT_W wide and saturate at full scale. A synchronous clear and a snapshot (latch) into shadow registers let slow control read a coherent set of counts through a registered readout mux. The block sits between the trigger-input conditioning and the slow-control register interface.

Parameters:
N_CH, 8, number of trigger input channels (1..32)
CNT_W, 16, counter width in bits (8..32)
EDGE_MODE, 1, 1 = count rising edges of in[i]; 0 = count every cycle in[i] is high
SEL_W, $clog2(N_CH) (min 1), width of rd_sel; derived, not overridden

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
in  input  N_CH  trigger inputs, synchronous to clk
enable  input  1  global count enable; 0 freezes all live counters
clear  input  1  synchronous clear of all live counters and saturation flags
latch  input  1  snapshot all live counters into the shadow bank
rd_sel  input  SEL_W  shadow-bank channel select
rd_data  output  CNT_W  registered shadow count of channel rd_sel
sat  output  N_CH  live saturation flags, 1 = counter at 2^CNT_W-1
latched_valid  output  1  one-cycle pulse, asserted the cycle after a latch is taken

Behaviour:
- Reset (async, active-high) forces these to 0 immediately: live counters, shadow bank, sat, rd_data, latched_valid, edge history.
- Count event, channel i:
  - EDGE_MODE=1: in[i]=1 and hist[i]=0. hist[i] <= in[i] every cycle, regardless of enable.
  - EDGE_MODE=0: in[i]=1.
  - With history reset to 0, an input already high when reset deasserts counts as one edge.
- Increment: on a count event with enable=1 and cnt[i] < 2^CNT_W-1, cnt[i] <= cnt[i]+1 at the next edge.
- Saturation: at 2^CNT_W-1 the counter holds; it never wraps. sat[i] = (cnt[i] == all ones), registered with the counter.
- Clear: clear=1 sets cnt <= 0 and sat <= 0 for all channels, and overrides any same-cycle increment. Edge history is not cleared.
- Latch: latch=1 sets shadow[i] <= cnt[i] for all i, capturing the pre-update value of that cycle. This holds even if the same cycle also increments or clears. The shadow bank is unaffected by clear.
- latched_valid = latch delayed by one clk and is 1 cycle wide. Back-to-back latch gives back-to-back pulses.
- Readout: rd_data <= shadow[rd_sel] every cycle, so latency is 1 clk from rd_sel or shadow change. rd_sel >= N_CH gives rd_data <= 0.
- enable=0: counters hold, and clear and latch still act.
- Widths: all comparisons are unsigned, at CNT_W bits. No carry-out is stored.
- Reset mid-count: all state returns to 0 asynchronously. The first eligible event after deassertion counts as 1.

Decomposition:
- Shared package trig_pkg holds:
  - CNT_W default
  - EDGE and LEVEL mode constants
  - a function cnt_max(width) that returns all ones
- One natural sub-module, trig_counter_ch: per-channel edge detect, saturating counter, sat flag and shadow register. It is instantiated N_CH times by generate.
- The top level holds the latched_valid register and the registered readout mux.

Test Plan:
- Reset, then EDGE_MODE=1, enable=1: in[0] held high 10 cycles, then low -> cnt[0]=1; latch -> rd_sel=0 gives rd_data=1 one cycle after shadow update.
- EDGE_MODE=0, enable=1: in[3] high 5 cycles, then latch -> shadow[3]=5; all other channels 0; latched_valid high for exactly 1 cycle.
- CNT_W=8, EDGE_MODE=0: in[1] high 300 cycles -> cnt[1]=255; sat[1]=1 from the cycle cnt reaches 255; no wrap; clear -> cnt[1]=0, sat[1]=0.
- Simultaneous events: cnt[2]=7 with a count event, latch and clear in one cycle -> shadow[2]=7, cnt[2]=0; next cycle latched_valid=1 and rd_data (rd_sel=2)=7.
- enable=0 with edges on all inputs -> counts unchanged; toggle rd_sel 0..N_CH -> rd_data follows shadow one cycle later, and rd_sel=N_CH gives 0.
- Assert reset asynchronously mid-burst, between clk edges -> all outputs 0 before the next edge; after release, in high gives first count 1.
